// File: rtl/alu_serial.sv
// Digit-serial ALU: consumes LSB-first operand digits, streams registered result digits one
// cycle later and reports end-of-operation flags when the last digit retires.
module alu_serial #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [2:0]       alu_op_i,
  input  logic             alu_start_i,
  input  logic             alu_valid_i,
  input  logic [DIGIT-1:0] rs1_i,
  input  logic [DIGIT-1:0] rs2_i,
  output logic [DIGIT-1:0] res_o,
  output logic             res_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             flag_z_o,
  output logic             flag_c_o,
  output logic             flag_n_o,
  output logic             flag_v_o,
  output logic             flag_lt_o
);

  localparam int unsigned NDIG = XLEN / DIGIT;
  localparam int unsigned IdxW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NDIG - 1);

  typedef enum logic [2:0] {
    OpAdd  = 3'b000,
    OpSub  = 3'b001,
    OpXor  = 3'b010,
    OpAnd  = 3'b011,
    OpOr   = 3'b100,
    OpSlt  = 3'b101,
    OpSltu = 3'b110,
    OpRsvd = 3'b111
  } op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             zacc_q, zacc_d;
  logic [DIGIT-1:0] res_q, res_d;
  logic             res_valid_q, res_valid_d;
  logic             done_q, done_d;
  logic             fz_q, fz_d, fc_q, fc_d, fn_q, fn_d, fv_q, fv_d, flt_q, flt_d;

  logic             start_beat, cont_beat, accept, last;
  op_e              op_cur;
  logic             is_sub, is_arith, cin;
  logic [DIGIT-1:0] b_eff, sum, dp, out_dig;
  logic [DIGIT:0]   cy;
  logic [IdxW-1:0]  idx_cur;
  logic             zero_cur;
  logic             new_z, new_c, new_n, new_v, new_lt;

  // Beat decode and per-digit datapath
  always_comb begin
    start_beat = alu_valid_i & alu_start_i;
    cont_beat  = alu_valid_i & ~alu_start_i & (state_q == StBusy);
    accept     = start_beat | cont_beat;
    op_cur     = start_beat ? op_e'(alu_op_i) : op_q;
    is_sub     = (op_cur == OpSub) || (op_cur == OpSlt) || (op_cur == OpSltu);
    is_arith   = is_sub || (op_cur == OpAdd);
    // The start beat seeds the chain; later beats continue from the stored carry.
    cin        = start_beat ? is_sub : carry_q;
    b_eff      = is_sub ? ~rs2_i : rs2_i;

    cy[0] = cin;
    sum   = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      sum[i]  = rs1_i[i] ^ b_eff[i] ^ cy[i];
      cy[i+1] = (rs1_i[i] & b_eff[i]) | (cy[i] & (rs1_i[i] ^ b_eff[i]));
    end

    dp      = '0;
    out_dig = '0;
    unique case (op_cur)
      OpAdd, OpSub: begin
        dp      = sum;
        out_dig = sum;
      end
      OpXor: begin
        dp      = rs1_i ^ rs2_i;
        out_dig = dp;
      end
      OpAnd: begin
        dp      = rs1_i & rs2_i;
        out_dig = dp;
      end
      OpOr: begin
        dp      = rs1_i | rs2_i;
        out_dig = dp;
      end
      // Compares stream zeros; the outcome leaves on flag_lt only.
      OpSlt, OpSltu: begin
        dp      = sum;
        out_dig = '0;
      end
      default: begin
        dp      = '0;
        out_dig = '0;
      end
    endcase

    idx_cur  = start_beat ? '0 : idx_q + 1'b1;
    last     = (idx_cur == LastIdx);
    zero_cur = (start_beat | zacc_q) & (dp == '0);

    new_c  = is_arith & cy[DIGIT];
    new_v  = is_arith & (cy[DIGIT-1] ^ cy[DIGIT]);
    new_n  = dp[DIGIT-1];
    new_z  = (op_cur != OpRsvd) & zero_cur;
    new_lt = 1'b0;
    if (op_cur == OpSlt) begin
      new_lt = new_n ^ new_v;
    end else if (op_cur == OpSltu) begin
      new_lt = ~new_c;
    end
  end

  // Next-state
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    zacc_d      = zacc_q;
    res_d       = res_q;
    res_valid_d = 1'b0;
    done_d      = 1'b0;
    fz_d        = fz_q;
    fc_d        = fc_q;
    fn_d        = fn_q;
    fv_d        = fv_q;
    flt_d       = flt_q;

    if (accept) begin
      op_d        = op_cur;
      idx_d       = idx_cur;
      zacc_d      = zero_cur;
      res_d       = out_dig;
      res_valid_d = 1'b1;
      if (is_arith) begin
        carry_d = cy[DIGIT];
      end
      if (last) begin
        state_d = StIdle;
        done_d  = 1'b1;
        fz_d    = new_z;
        fc_d    = new_c;
        fn_d    = new_n;
        fv_d    = new_v;
        flt_d   = new_lt;
      end else begin
        state_d = StBusy;
        if (start_beat) begin
          fz_d  = 1'b0;
          fc_d  = 1'b0;
          fn_d  = 1'b0;
          fv_d  = 1'b0;
          flt_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      op_q        <= OpAdd;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      zacc_q      <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      fz_q        <= 1'b0;
      fc_q        <= 1'b0;
      fn_q        <= 1'b0;
      fv_q        <= 1'b0;
      flt_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      zacc_q      <= zacc_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
      fz_q        <= fz_d;
      fc_q        <= fc_d;
      fn_q        <= fn_d;
      fv_q        <= fv_d;
      flt_q       <= flt_d;
    end
  end

  assign res_o       = res_q;
  assign res_valid_o = res_valid_q;
  assign busy_o      = (state_q == StBusy);
  assign done_o      = done_q;
  assign flag_z_o    = fz_q;
  assign flag_c_o    = fc_q;
  assign flag_n_o    = fn_q;
  assign flag_v_o    = fv_q;
  assign flag_lt_o   = flt_q;

endmodule

// File: tb/tb_alu_serial.sv
// Scoreboard bench for alu_serial: four XLEN=8 instances (DIGIT 1,2,4,8) driven with directed
// and random ops, checked against a whole-word arithmetic reference model.
module tb_alu_serial;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_XOR = 3'd2, OP_AND = 3'd3;
  localparam logic [2:0] OP_OR = 3'd4, OP_SLT = 3'd5, OP_SLTU = 3'd6;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       first;
    logic [4:0] fl;  // {z, c, n, v, lt}
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int k, input logic [15:0] act,
                       input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s inst%0d actual=%h required=%h at %0t", name, k, act, req, $time);
    end
  endtask

  // Whole-word reference: result word and {z, c, n, v, lt}
  function automatic void model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                                output logic [7:0] r, output logic [4:0] fl);
    logic [8:0] s;
    logic [7:0] nb, w;
    logic       z, c, n, v, lt;
    nb = ~y;
    r  = 8'h00;
    z  = 1'b0; c = 1'b0; n = 1'b0; v = 1'b0; lt = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, x} + {1'b0, y};
        w = s[7:0];
        r = w; c = s[8]; n = w[7]; z = (w == 8'h00);
        v = (x[7] == y[7]) && (w[7] != x[7]);
      end
      OP_SUB, OP_SLT, OP_SLTU: begin
        s = {1'b0, x} + {1'b0, nb} + 9'd1;
        w = s[7:0];
        c = s[8]; n = w[7]; z = (w == 8'h00);
        v = (x[7] != y[7]) && (w[7] != x[7]);
        if (op == OP_SUB) r = w;
        if (op == OP_SLT) lt = ($signed(x) < $signed(y));
        if (op == OP_SLTU) lt = (x < y);
      end
      OP_XOR, OP_AND, OP_OR: begin
        w = (op == OP_XOR) ? (x ^ y) : (op == OP_AND) ? (x & y) : (x | y);
        r = w; n = w[7]; z = (w == 8'h00);
      end
      default: ;
    endcase
    fl = {z, c, n, v, lt};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int D  = 1 << g;
    localparam int ND = 8 / D;

    logic         rst_n;
    logic [2:0]   op;
    logic         start, valid;
    logic [D-1:0] a, b, res;
    logic         res_valid, busy, done, fz, fc, fn, fv, flt;
    exp_t         q[$];
    bit           fin;
    bit           exp_busy;

    alu_serial #(.XLEN(8), .DIGIT(D)) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .alu_op_i   (op),
      .alu_start_i(start),
      .alu_valid_i(valid),
      .rs1_i      (a),
      .rs2_i      (b),
      .res_o      (res),
      .res_valid_o(res_valid),
      .busy_o     (busy),
      .done_o     (done),
      .flag_z_o   (fz),
      .flag_c_o   (fc),
      .flag_n_o   (fn),
      .flag_v_o   (fv),
      .flag_lt_o  (flt)
    );

    task automatic gap_cycle();
      check("busy_gap", g, 16'(busy), 16'(exp_busy));
      valid = 1'b0;
      start = 1'($urandom);
      op    = 3'($urandom);
      a     = D'($urandom);
      @(negedge clk);
    endtask

    task automatic idle_beat();
      check("busy_idle", g, 16'(busy), 16'(exp_busy));
      valid = 1'b1;
      start = 1'b0;
      a     = D'($urandom);
      b     = D'($urandom);
      @(negedge clk);
    endtask

    // Feed nfeed digits of op o (nfeed < ND leaves the op unfinished)
    task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                          input int gap_pct, input int fixed_gap, input int nfeed);
      logic [7:0]   r;
      logic [4:0]   fl;
      logic [D-1:0] rd;
      exp_t         e;
      model(o, x, y, r, fl);
      for (int i = 0; i < nfeed; i++) begin
        if (i > 0) begin
          for (int k = 0; k < fixed_gap; k++) gap_cycle();
          for (int k = 0; k < 3 && $urandom_range(99) < gap_pct; k++) gap_cycle();
        end
        check("busy", g, 16'(busy), 16'(exp_busy));
        valid   = 1'b1;
        start   = (i == 0);
        op      = (i == 0) ? o : 3'($urandom);
        a       = x[i*D +: D];
        b       = y[i*D +: D];
        rd      = r[i*D +: D];
        e.d     = 8'(rd);
        e.last  = (i == ND - 1);
        e.first = (i == 0);
        e.fl    = fl;
        q.push_back(e);
        exp_busy = (i != ND - 1);
        @(negedge clk);
      end
    endtask

    task automatic do_reset();
      valid = 1'b0;
      start = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check("reset_outputs", g, 16'({res, res_valid, busy, done, fz, fc, fn, fv, flt}), 16'h0);
      check("reset_queue", g, 16'(q.size()), 16'h0);
      q.delete();
      rst_n    = 1'b1;
      exp_busy = 1'b0;
    endtask

    initial begin
      logic [2:0] o;
      logic [7:0] x, y;
      int         sel;
      fin = 1'b0; exp_busy = 1'b0;
      rst_n = 1'b0; valid = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check("reset_state", g, 16'({res, res_valid, busy, done, fz, fc, fn, fv, flt}), 16'h0);
      rst_n = 1'b1;

      run_op(OP_ADD, 8'h7F, 8'h01, 0, 0, ND);
      idle_beat();
      run_op(OP_SUB, 8'h05, 8'h05, 0, 2, ND);
      run_op(OP_SLT, 8'hFE, 8'h01, 0, 0, ND);
      run_op(OP_SLTU, 8'hFE, 8'h01, 0, 0, ND);
      run_op(OP_ADD, 8'($urandom), 8'($urandom), 0, 0, (ND > 3) ? 3 : ND - 1);
      run_op(OP_AND, 8'hF0, 8'h3C, 0, 0, ND);
      run_op(OP_OR, 8'h0F, 8'hF0, 0, 0, ND);
      run_op(OP_SUB, 8'h9A, 8'h37, 0, 0, (ND > 2) ? 2 : ND - 1);
      do_reset();
      run_op(OP_ADD, 8'h01, 8'h01, 0, 0, ND);

      for (int n = 0; n < 80; n++) begin
        sel = $urandom_range(99);
        o   = 3'($urandom_range(7));
        x   = 8'($urandom);
        y   = 8'($urandom);
        if (sel < 10) begin
          run_op(o, x, y, 20, 0, $urandom_range(ND - 1));
          if (sel < 4) do_reset();
        end else if (sel < 18 && !exp_busy) begin
          idle_beat();
        end else begin
          run_op(o, x, y, 25, 0, ND);
        end
      end

      valid = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("drain", g, 16'(q.size()), 16'h0);
      fin = 1'b1;
    end

    // Monitor: pops one expectation per presented digit
    always @(negedge clk) begin
      exp_t e;
      if (res_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_res_valid inst%0d actual=1 required=0 at %0t", g, $time);
        end else begin
          e = q.pop_front();
          check("res", g, 16'(res), 16'(e.d));
          check("done", g, 16'(done), 16'(e.last));
          if (e.last) begin
            check("flags", g, 16'({fz, fc, fn, fv, flt}), 16'(e.fl));
          end else if (e.first) begin
            check("flags_cleared", g, 16'({fz, fc, fn, fv, flt}), 16'h0);
          end
        end
      end else if (rst_n) begin
        check("done_idle", g, 16'(done), 16'h0);
      end
    end
  end

  initial begin
    bit all_fin;
    all_fin = 1'b0;
    for (int c = 0; c < 50000 && !all_fin; c++) begin
      @(posedge clk);
      all_fin = g_inst[0].fin & g_inst[1].fin & g_inst[2].fin & g_inst[3].fin;
    end
    if (!all_fin) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=unfinished required=finished");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_serial.md
# alu_serial

Parametrised digit-serial ALU for the bit-serial CPU datapath. Consumes both operands as LSB-first digits of `DIGIT` bits, produces registered result digits one cycle later, and reports end-of-operation flags (zero, carry, negative, overflow, less-than) when the last digit retires. It replaces the fixed 1-bit ALU. It adds a digit counter, a start/valid handshake with stall support, and set-less-than operations.

## Interface
Parameters:
- `XLEN`, 32: operand width in bits.
- `DIGIT`, 1: bits processed per accepted beat. Must divide `XLEN`. `NDIG = XLEN/DIGIT`.

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `alu_op`  in  3: operation code, sampled only on the start beat.
- `alu_start`  in  1: marks the first (LSB) digit of a new operation. Qualified by `alu_valid`.
- `alu_valid`  in  1: a digit is presented this cycle.
- `rs1`  in  DIGIT: operand A digit.
- `rs2`  in  DIGIT: operand B digit.
- `res`  out  DIGIT: result digit, registered.
- `res_valid`  out  1: `res` holds a valid digit this cycle.
- `busy`  out  1: an operation is in progress (first digit accepted, last not yet).
- `done`  out  1: single-cycle pulse with the last `res_valid`.
- `flag_z`, `flag_c`, `flag_n`, `flag_v`, `flag_lt`  out  1 each: flags, valid from `done` until the next start beat.

## Operation
Opcodes:
- `000` ADD: `rs1 + rs2`.
- `001` SUB: `rs1 + ~rs2 + 1`.
- `010` XOR.
- `011` AND.
- `100` OR.
- `101` SLT (signed).
- `110` SLTU (unsigned).
- `111` reserved. Result digits are 0 and all flags are 0.

SLT and SLTU run the SUB datapath internally. Their streamed `res` digits are forced to 0. The comparison is delivered on `flag_lt` only, and writeback inserts it as bit 0.

Beat acceptance:
- A beat is accepted when `alu_valid`=1.
- A start beat is `alu_valid & alu_start`. It latches `alu_op`, sets the digit index to 0, sets `busy`, and clears the zero accumulator.
- The carry seed is used on the start beat in place of the stored carry: 1 for SUB/SLT/SLTU, 0 otherwise.
- A non-start accepted beat while `busy`=1 advances the index by 1.
- A non-start beat while idle is ignored: no `res_valid`, no state change.
- `alu_start` with `alu_valid`=0 is ignored.

Carry chain:
- A `DIGIT`-wide ripple adder runs per beat.
- Carry out of the digit MSB is stored and used as carry-in for the next beat.
- Logic ops never update the carry.

Last digit (index `NDIG-1`) flag computation:
- `flag_c` = carry out of bit `XLEN-1` (for SUB, 1 = no borrow). It is 0 for logic ops.
- `flag_n` = result bit `XLEN-1` of the datapath (the difference, for SLT/SLTU).
- `flag_v` = carry into MSB XOR carry out of MSB, for ADD/SUB/SLT/SLTU. It is 0 otherwise.
- `flag_z` = 1 when every datapath result digit was 0. For SLT/SLTU this is the difference, not the forced output.
- `flag_lt`: SLT = `flag_n ^ flag_v`; SLTU = `~flag_c`; 0 for all other ops.

On the last beat, `busy` clears. Flags hold until the next start beat, which clears them to 0 on the following cycle.

Boundary conditions:
- Gaps (`alu_valid`=0 mid-op) stall: carry, index and accumulator hold, and `res_valid`=0 for that cycle.
- A start beat while `busy`=1 aborts the current op without `done` and begins the new one on that beat.
- A start beat in the same cycle that `done` is asserted (back-to-back ops) is legal.
- When `NDIG`=1 (`DIGIT`=`XLEN`), the start beat is also the last beat.
- Reset mid-operation discards the op. No `done` is issued.

## Timing
- Reset values: `res`=0, `res_valid`=0, `busy`=0, `done`=0, all flags 0, carry 0, index 0.
- Latency: a digit accepted in cycle t appears on `res` with `res_valid`=1 in cycle t+1.
- `done` and the flags update in cycle t+1 for a last beat in cycle t.
- `busy` rises in cycle t+1 after a start beat and falls in cycle t+1 after the last beat.
- For `NDIG`=1, `busy` stays 0.
- Throughput: one digit per cycle. An op with no gaps takes `NDIG` cycles plus 1 cycle latency.
- No combinational path from any input to any output.

## Test plan
- XLEN=8, DIGIT=1, ADD 0x7F+0x01, no gaps:
  - `res` stream is 0x80 LSB-first, with 8 consecutive `res_valid`.
  - `done` asserts with bit 7.
  - Flags: `flag_n`=1, `flag_v`=1, `flag_c`=0, `flag_z`=0.
- XLEN=8, DIGIT=4, SUB 0x05-0x05 with a 2-cycle gap between the digits:
  - `res` stream is 0x0, then 0x0.
  - Flags: `flag_z`=1, `flag_c`=1, `flag_lt`=0.
  - `res_valid` is low during the gap.
- XLEN=8, DIGIT=2, SLT with 0xFE (-2) vs 0x01:
  - All `res` digits are 0.
  - `flag_lt`=1.
  - SLTU with the same operands gives `flag_lt`=0.
- XLEN=8, DIGIT=1, abort case:
  - Start ADD, feed 3 digits, then issue a new start beat with AND 0xF0 & 0x3C.
  - No `done` is issued for the ADD.
  - The AND streams 0x30, then `done`, with `flag_c`=0.
- XLEN=8, DIGIT=8, OR 0x0F|0xF0:
  - Single beat, `busy` stays 0.
  - Next cycle: `res`=0xFF, `done`=1, `flag_n`=1.
- Reset after 2 digits of a SUB:
  - All outputs return to 0 the next cycle.
  - A following ADD 0x01+0x01 yields 0x02, which shows no stale carry.
